led_dai_serializer: RTL and testbench

Upstream feeder for the LED display controller's DCK domain. Accepts 16-bit gray-level pixel words over a valid/ready handshake and emits them as the serial DAI/DEN stream the controller captures: LSB first, one bit per DCK, DEN high for exactly 16 cycles per pixel, then a DEN-low gap. Tracks the position within a 512-pixel frame (32 scanlines × 16 columns) and flags framing errors.

---
 rtl/led_pkg.sv | 22 ++
 rtl/led_dai_serializer.sv | 102 ++++++++++
 tb/tb_led_dai_serializer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Constants and FSM state type shared by the LED display
//               controller, its DAI serializer and any frame source.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

  localparam int LED_PIX_W     = 16;
  localparam int LED_FRAME_PIX = 512;
  localparam int LED_SL_PIX    = 16;
  localparam int LED_SL_NUM    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } led_state_t;

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_dai_serializer.sv
`default_nettype none
// ============================================================================
// Module      : led_dai_serializer
// Description : Serialises 16-bit pixel words LSB-first onto DAI/DEN with a
//               DEN-low gap between pixels, tracking frame position.
// Revision    : 1.0 - initial release
// ============================================================================
module led_dai_serializer
  import led_pkg::*;
#(
  parameter int PIX_W     = LED_PIX_W,
  parameter int FRAME_PIX = LED_FRAME_PIX,
  parameter int GAP       = 1
) (
  input  logic             DCK,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  input  logic             pix_last,
  output logic             pix_ready,
  output logic             DAI,
  output logic             DEN,
  output logic [8:0]       pix_cnt,
  output logic             frame_done,
  output logic             frame_err
);

  localparam logic [3:0] c_last_bit = 4'(PIX_W - 1);
  localparam logic [3:0] c_gap_last = 4'(GAP - 1);
  localparam logic [8:0] c_last_pix = 9'(FRAME_PIX - 1);

  led_state_t       r_state;
  logic [PIX_W-1:0] r_shift;
  logic [3:0]       r_bit_cnt;
  logic [3:0]       r_gap_cnt;

  logic w_ready;
  logic w_accept;
  logic w_at_last_pix;

  assign w_ready       = (r_state == ST_IDLE) ||
                         ((r_state == ST_GAP) && (r_gap_cnt == c_gap_last));
  assign w_accept      = pix_valid && w_ready;
  assign w_at_last_pix = (pix_cnt == c_last_pix);
  assign pix_ready     = w_ready;

  always_ff @(posedge DCK or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= 4'd0;
      r_gap_cnt  <= 4'd0;
      DAI        <= 1'b0;
      DEN        <= 1'b0;
      pix_cnt    <= 9'd0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // A pixel's pix_last must agree with its frame slot; mismatch is only flagged.
      if (w_accept && (pix_last != w_at_last_pix)) begin
        frame_err <= 1'b1;
      end

      if (w_accept) begin
        r_state   <= ST_SHIFT;
        r_shift   <= pix_data;
        r_bit_cnt <= 4'd0;
        DEN       <= 1'b1;
        DAI       <= pix_data[0];
      end else begin
        case (r_state)
          ST_SHIFT: begin
            if (r_bit_cnt == c_last_bit) begin
              r_state    <= ST_GAP;
              r_gap_cnt  <= 4'd0;
              DEN        <= 1'b0;
              DAI        <= 1'b0;
              pix_cnt    <= w_at_last_pix ? 9'd0 : pix_cnt + 9'd1;
              frame_done <= w_at_last_pix;
            end else begin
              r_shift   <= r_shift >> 1;
              DAI       <= r_shift[1];
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          ST_GAP: begin
            if (r_gap_cnt == c_gap_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_gap_cnt <= r_gap_cnt + 4'd1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule : led_dai_serializer
`default_nettype wire

// File: tb/tb_led_dai_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_dai_serializer
// Description : Randomised scoreboard bench for led_dai_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_dai_serializer;
  import led_pkg::*;

  localparam int GAP = 1;

  logic        DCK = 1'b0;
  logic        rst_n;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_last;
  logic        pix_ready, DAI, DEN, frame_done, frame_err;
  logic [8:0]  pix_cnt;

  logic        g3_valid;
  logic [15:0] g3_data;
  logic        g3_ready, g3_dai, g3_den, g3_fd, g3_fe;
  logic [8:0]  g3_cnt;

  always #5 DCK = ~DCK;

  led_dai_serializer #(.GAP(GAP)) u_dut (
    .DCK(DCK), .rst_n(rst_n), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_last(pix_last), .pix_ready(pix_ready), .DAI(DAI), .DEN(DEN),
    .pix_cnt(pix_cnt), .frame_done(frame_done), .frame_err(frame_err)
  );

  led_dai_serializer #(.GAP(3)) u_dut_g3 (
    .DCK(DCK), .rst_n(rst_n), .pix_data(g3_data), .pix_valid(g3_valid),
    .pix_last(1'b0), .pix_ready(g3_ready), .DAI(g3_dai), .DEN(g3_den),
    .pix_cnt(g3_cnt), .frame_done(g3_fd), .frame_err(g3_fe)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected words, pushed on acceptance and popped when a DEN run ends.
  logic [15:0] sb[$];

  // Monitor: rebuilds words from DEN/DAI and checks them against the scoreboard.
  int          completed;
  int          fd_count = 0;
  int          den_run, low_run;
  logic        prev_den;
  logic [15:0] cap;
  logic [15:0] exp_word;

  always @(negedge DCK) begin
    if (!rst_n) begin
      den_run   = 0;
      low_run   = 100;
      prev_den  = 1'b0;
      completed = 0;
      sb.delete();
    end else begin
      if (DEN) begin
        if (!prev_den) check("den_low_run_min", 32'(low_run >= GAP), 1);
        if (den_run < 16) cap[den_run] = DAI;
        if (den_run == 16) check("den_high_too_long", den_run, 16 - 1);
        den_run++;
      end else begin
        check("dai_zero_when_den_low", DAI, 0);
        if (prev_den) begin
          check("den_high_run", den_run, 16);
          completed++;
          if (sb.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
          end else begin
            exp_word = sb.pop_front();
            check("word", cap, exp_word);
          end
          check("pix_cnt_after_pixel", pix_cnt, completed % 512);
          check("frame_done", frame_done, 32'((completed % 512) == 0));
          if (frame_done) fd_count++;
          den_run = 0;
          low_run = 0;
        end else if (frame_done) begin
          check("frame_done_spurious", frame_done, 0);
        end
        low_run++;
      end
      prev_den = DEN;
    end
  end

  // Reference model of the framing rules.
  int   accepted;
  logic exp_err;
  time  t_first, t_last;

  task automatic tick();
    @(posedge DCK);
    #1;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    pix_data  = 16'($urandom);
    pix_last  = 1'($urandom);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    rst_n     = 1'b0;
    accepted  = 0;
    exp_err   = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    int n;
    n         = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = last;
    while (!pix_ready && n < 100) begin
      tick();
      n++;
    end
    if (!pix_ready) begin
      check("ready_timeout", 0, 1);
      pix_valid = 1'b0;
      return;
    end
    sb.push_back(d);
    exp_err = exp_err | (last != ((accepted % 512) == 511));
    accepted++;
    tick();
    check("frame_err", frame_err, exp_err);
  endtask

  logic        den_tr[60];
  logic        rdy_tr[60];
  logic        dai_tr[60];
  logic [15:0] g3_word;
  int          fd_base;
  int          s;

  initial begin
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 16'h0;
    pix_last  = 1'b0;
    g3_valid  = 1'b0;
    g3_data   = 16'h0;
    do_reset();

    check("rst_den", DEN, 0);
    check("rst_dai", DAI, 0);
    check("rst_pix_cnt", pix_cnt, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_pix_ready", pix_ready, 1);

    // Single pixel.
    send(16'hA5C3, 1'b0);
    idle(20);
    check("single_pix_cnt", pix_cnt, 1);
    check("single_den_low", DEN, 0);
    check("single_drained", sb.size(), 0);

    // Full frame, back to back.
    do_reset();
    fd_base = fd_count;
    for (int i = 0; i < 512; i++) begin
      send(16'(i), 1'(i == 511));
      if (i == 0)   t_first = $time;
      if (i == 511) t_last  = $time;
    end
    idle(30);
    check("stream_period", 32'((t_last - t_first) / 10), 511 * (16 + GAP));
    check("stream_frame_done_once", fd_count - fd_base, 1);
    check("stream_pix_cnt_wrap", pix_cnt, 0);
    check("stream_frame_err", frame_err, 0);
    check("stream_drained", sb.size(), 0);

    // Two frames with random throttling.
    do_reset();
    fd_base = fd_count;
    for (int i = 0; i < 1024; i++) begin
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      send(16'($urandom), 1'((i % 512) == 511));
    end
    idle(30);
    check("rand_frame_done_twice", fd_count - fd_base, 2);
    check("rand_frame_err", frame_err, 0);
    check("rand_drained", sb.size(), 0);

    // Early pix_last at pixel 100.
    do_reset();
    for (int i = 0; i < 515; i++) begin
      send(16'($urandom), 1'(i == 100));
      if (i == 99)  check("early_last_err_before", frame_err, 0);
      if (i == 100) check("early_last_err_rise", frame_err, 1);
    end
    idle(30);
    check("early_last_err_sticky", frame_err, 1);
    check("early_last_pix_cnt", pix_cnt, 3);
    check("early_last_drained", sb.size(), 0);

    // Reset during bit 7.
    do_reset();
    send(16'h1234, 1'b0);
    repeat (7) tick();
    check("midrst_den_before", DEN, 1);
    #2;
    pix_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("midrst_den", DEN, 0);
    check("midrst_dai", DAI, 0);
    check("midrst_ready", pix_ready, 1);
    check("midrst_pix_cnt", pix_cnt, 0);
    accepted = 0;
    exp_err  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send(16'hBEEF, 1'b0);
    idle(25);
    check("midrst_next_pix_cnt", pix_cnt, 1);
    check("midrst_drained", sb.size(), 0);

    // GAP=3 instance, back to back.
    g3_data  = 16'h5A3C;
    g3_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge DCK);
      den_tr[i] = g3_den;
      rdy_tr[i] = g3_ready;
      dai_tr[i] = g3_dai;
    end
    g3_valid = 1'b0;
    tick();
    s = -1;
    for (int i = 0; i < 30; i++) if (s < 0 && den_tr[i]) s = i;
    if (s < 0) begin
      check("g3_den_seen", 0, 1);
    end else begin
      for (int i = 0; i < 16; i++) g3_word[i] = dai_tr[s + i];
      check("g3_word", g3_word, 16'h5A3C);
      check("g3_den_last_bit", den_tr[s + 15], 1);
      check("g3_gap0", den_tr[s + 16], 0);
      check("g3_gap1", den_tr[s + 17], 0);
      check("g3_gap2", den_tr[s + 18], 0);
      check("g3_restart", den_tr[s + 19], 1);
      check("g3_rdy0", rdy_tr[s + 16], 0);
      check("g3_rdy1", rdy_tr[s + 17], 0);
      check("g3_rdy2", rdy_tr[s + 18], 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_led_dai_serializer
`default_nettype wire
